pbs_battle_ctrl: RTL

Turn-sequencing controller for the Pokémon battle-simulator datapath. It takes the player's move selection and confirm strobe, then runs one full turn: player attack on the AI, KO check, AI attack on the player, KO check. It drives the datapath's trainer-mux select, RNG freeze, HP-load and damage-apply strobes, and declares the winner. It sits between the board I/O (switches/keys) and the datapath, one instance per game.

---
 rtl/pbs_pkg.sv | 42 ++++
 rtl/pbs_hold_timer.sv | 38 +++
 rtl/pbs_battle_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pbs_pkg.sv
// pbs_pkg
// Shared definitions for the battle-simulator control slice: the turn FSM
// state encoding, winner codes and the trainer-select / target constants
// that both the controller and the datapath use.
package pbs_pkg;

  // One state per phase of a turn; encodings are visible on state_dbg.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    P_SEL    = 4'd1,
    P_SETTLE = 4'd2,
    P_ROLL   = 4'd3,
    P_LOAD   = 4'd4,
    P_APPLY  = 4'd5,
    P_HOLD   = 4'd6,
    P_CHECK  = 4'd7,
    A_SEL    = 4'd8,
    A_SETTLE = 4'd9,
    A_ROLL   = 4'd10,
    A_APPLY  = 4'd11,
    A_HOLD   = 4'd12,
    A_CHECK  = 4'd13,
    OVER     = 4'd14
  } state_t;

  localparam logic [1:0] WINNER_NONE   = 2'b00;
  localparam logic [1:0] WINNER_PLAYER = 2'b01;
  localparam logic [1:0] WINNER_AI     = 2'b10;

  localparam logic ACTR_PLAYER   = 1'b0;
  localparam logic ACTR_AI       = 1'b1;
  localparam logic TARGET_PLAYER = 1'b0;
  localparam logic TARGET_AI     = 1'b1;

  localparam logic [7:0] TURN_MAX = 8'd255;

  // A game is "busy" whenever a turn is in flight.
  function automatic logic is_busy(input state_t s);
    return !((s == IDLE) || (s == OVER));
  endfunction

endpackage

// File: rtl/pbs_hold_timer.sv
// pbs_hold_timer
// Counts the display-hold interval after each attack. Shared by both HOLD
// states of the turn FSM.
//   clk      system clock
//   rst      synchronous, active-low reset
//   start_i  clears the count; asserted in the cycle before a HOLD state
//   run_i    high while the FSM sits in a HOLD state
//   done_o   high in the last of HOLD_CYCLES hold cycles
module pbs_hold_timer #(
  parameter int HOLD_CYCLES = 8,
  parameter int HOLD_W      = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic done_o
);

  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] count_q;

  // Count starts from zero on entry to a HOLD state, so the state lasts
  // exactly HOLD_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (start_i) begin
      count_q <= '0;
    end else if (run_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done_o = run_i && (count_q == LAST);

endmodule

// File: rtl/pbs_battle_ctrl.sv
// pbs_battle_ctrl
// Turn sequencer for the battle-simulator datapath. A confirm pulse in IDLE
// runs one full turn: player attack, AI KO check, AI attack, player KO
// check. All outputs are registers, decoded from the next state.
//   clk, rst          clock, synchronous active-low reset
//   confirm, new_game one-cycle key pulses (start turn / leave OVER)
//   p_move_in         player move switches, latched on confirm
//   p_hp, AI_hp       current HP from the datapath
//   accu, accu_roll   accuracy of muxed move and random roll
//   p_move            latched player move
//   actr, target      trainer mux select and damage target
//   stop              freezes datapath RNGs during a roll
//   load_ai_hp, app_ai_dmg, app_pl_dmg   datapath strobes
//   busy, hit, winner, turn_cnt, state_dbg  status
module pbs_battle_ctrl
  import pbs_pkg::*;
#(
  parameter int HOLD_CYCLES = 8,
  parameter int HOLD_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirm,
  input  logic       new_game,
  input  logic [1:0] p_move_in,
  input  logic [3:0] p_hp,
  input  logic [3:0] AI_hp,
  input  logic [3:0] accu,
  input  logic [3:0] accu_roll,
  output logic [1:0] p_move,
  output logic       actr,
  output logic       target,
  output logic       stop,
  output logic       load_ai_hp,
  output logic       app_ai_dmg,
  output logic       app_pl_dmg,
  output logic       busy,
  output logic       hit,
  output logic [1:0] winner,
  output logic [7:0] turn_cnt,
  output logic [3:0] state_dbg
);

  state_t     state_q, state_d;
  logic [1:0] p_move_q, p_move_d;
  logic       hit_q, hit_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] turn_q, turn_d;
  logic       actr_q, actr_d;
  logic       target_q, target_d;
  logic       stop_q, stop_d;
  logic       load_q, load_d;
  logic       app_ai_q, app_ai_d;
  logic       app_pl_q, app_pl_d;
  logic       busy_q, busy_d;

  logic hold_start;
  logic hold_run;
  logic hold_done;

  // Both APPLY states always lead into their HOLD state, so they arm the timer.
  assign hold_start = (state_q == P_APPLY) || (state_q == A_APPLY);
  assign hold_run   = (state_q == P_HOLD)  || (state_q == A_HOLD);

  pbs_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W     (HOLD_W)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .start_i(hold_start),
    .run_i  (hold_run),
    .done_o (hold_done)
  );

  // Next-state and register-update logic for the turn sequence. HP is only
  // read in the CHECK states, which come at least one hold cycle after the
  // apply strobe so the datapath write has landed.
  always_comb begin
    state_d  = state_q;
    p_move_d = p_move_q;
    hit_d    = hit_q;
    winner_d = winner_q;
    turn_d   = turn_q;
    case (state_q)
      IDLE: begin
        if (confirm) begin
          p_move_d = p_move_in;
          state_d  = P_SEL;
        end
      end
      P_SEL:    state_d = P_SETTLE;
      P_SETTLE: state_d = P_ROLL;
      P_ROLL: begin
        hit_d   = (accu_roll <= accu);
        state_d = P_LOAD;
      end
      P_LOAD:   state_d = P_APPLY;
      P_APPLY:  state_d = P_HOLD;
      P_HOLD:   if (hold_done) state_d = P_CHECK;
      P_CHECK: begin
        if (AI_hp == 4'd0) begin
          winner_d = WINNER_PLAYER;
          state_d  = OVER;
        end else begin
          state_d = A_SEL;
        end
      end
      A_SEL:    state_d = A_SETTLE;
      A_SETTLE: state_d = A_ROLL;
      A_ROLL: begin
        hit_d   = (accu_roll <= accu);
        state_d = A_APPLY;
      end
      A_APPLY:  state_d = A_HOLD;
      A_HOLD:   if (hold_done) state_d = A_CHECK;
      A_CHECK: begin
        if (turn_q != TURN_MAX) turn_d = turn_q + 8'd1;
        if (p_hp == 4'd0) begin
          winner_d = WINNER_AI;
          state_d  = OVER;
        end else begin
          state_d = IDLE;
        end
      end
      OVER: begin
        if (new_game) begin
          winner_d = WINNER_NONE;
          turn_d   = 8'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up
  // with the registered state they describe.
  always_comb begin
    actr_d   = ACTR_PLAYER;
    target_d = TARGET_PLAYER;
    stop_d   = 1'b0;
    load_d   = 1'b0;
    app_ai_d = 1'b0;
    app_pl_d = 1'b0;
    busy_d   = is_busy(state_d);
    case (state_d)
      P_SEL, P_SETTLE, P_LOAD: target_d = TARGET_AI;
      P_ROLL: begin
        target_d = TARGET_AI;
        stop_d   = 1'b1;
      end
      P_APPLY: begin
        target_d = TARGET_AI;
        app_ai_d = hit_d;
      end
      A_SEL, A_SETTLE: actr_d = ACTR_AI;
      A_ROLL: begin
        actr_d = ACTR_AI;
        stop_d = 1'b1;
      end
      A_APPLY: begin
        actr_d   = ACTR_AI;
        app_pl_d = hit_d;
      end
      default: ;
    endcase
    if (state_d == P_LOAD) load_d = 1'b1;
  end

  // State and output registers; reset abandons any turn in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      p_move_q <= 2'b00;
      hit_q    <= 1'b0;
      winner_q <= WINNER_NONE;
      turn_q   <= 8'd0;
      actr_q   <= ACTR_PLAYER;
      target_q <= TARGET_PLAYER;
      stop_q   <= 1'b0;
      load_q   <= 1'b0;
      app_ai_q <= 1'b0;
      app_pl_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_move_q <= p_move_d;
      hit_q    <= hit_d;
      winner_q <= winner_d;
      turn_q   <= turn_d;
      actr_q   <= actr_d;
      target_q <= target_d;
      stop_q   <= stop_d;
      load_q   <= load_d;
      app_ai_q <= app_ai_d;
      app_pl_q <= app_pl_d;
      busy_q   <= busy_d;
    end
  end

  assign p_move     = p_move_q;
  assign actr       = actr_q;
  assign target     = target_q;
  assign stop       = stop_q;
  assign load_ai_hp = load_q;
  assign app_ai_dmg = app_ai_q;
  assign app_pl_dmg = app_pl_q;
  assign busy       = busy_q;
  assign hit        = hit_q;
  assign winner     = winner_q;
  assign turn_cnt   = turn_q;
  assign state_dbg  = state_q;

endmodule
